canvas_painter: RTL and testbench

Parametrised drawing-canvas engine between the mouse/cursor logic and the MNIST inference datapath. It converts cursor screen coordinates into a GRID×GRID intensity map held in on-chip RAM. It paints or erases with a selectable 1×1 or 3×3 brush using saturating arithmetic, clears the canvas by hardware sweep, and streams the finished image row-major to the network over a valid/ready handshake.

---
 rtl/canvas_pkg.sv | 34 +++
 rtl/canvas_ram.sv | 30 +++
 rtl/canvas_painter.sv | 207 ++++++++++++++++++++
 tb/tb_canvas_painter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// Shared types and helpers for the drawing canvas: FSM state encoding,
// saturating cell arithmetic and cell-count helpers.
package canvas_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PAINT_RD  = 3'd2,
    ST_PAINT_WR  = 3'd3,
    ST_READ_ADDR = 3'd4,
    ST_READ_HOLD = 3'd5
  } canvas_state_t;

  localparam int unsigned DEF_GRID  = 32'd28;
  localparam int unsigned NUM_CELLS = DEF_GRID * DEF_GRID;
  localparam int unsigned CELL_AW   = $clog2(NUM_CELLS);

  function automatic int unsigned num_cells(input int unsigned grid);
    return grid * grid;
  endfunction

  // Clamp at max_v instead of wrapping; compare before adding so no overflow.
  function automatic int unsigned cell_sat_add(input int unsigned old_v,
                                               input int unsigned inc_v,
                                               input int unsigned max_v);
    return (old_v > max_v - inc_v) ? max_v : old_v + inc_v;
  endfunction

  function automatic int unsigned cell_sat_sub(input int unsigned old_v,
                                               input int unsigned inc_v);
    return (old_v < inc_v) ? 32'd0 : old_v - inc_v;
  endfunction

endpackage

// File: rtl/canvas_ram.sv
// Single-port canvas storage: synchronous write, registered read with
// one cycle of latency.
module canvas_ram
  import canvas_pkg::*;
#(
  parameter int unsigned DEPTH = NUM_CELLS,
  parameter int unsigned AW    = CELL_AW,
  parameter int unsigned W     = 32'd16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Read-first port: the read register sees the old contents on a write edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/canvas_painter.sv
// Canvas engine: maps cursor coordinates to cells, paints/erases with a
// saturating brush, sweeps the canvas clear and streams it row-major.
module canvas_painter
  import canvas_pkg::*;
#(
  parameter int unsigned GRID  = 32'd28,
  parameter int unsigned CELL  = 32'd14,
  parameter int unsigned X0    = 32'd200,
  parameter int unsigned Y0    = 32'd44,
  parameter int unsigned W     = 32'd16,
  parameter int unsigned INC   = 32'd500,
  parameter int unsigned MAX   = 32'd2048,
  parameter int unsigned BRUSH = 32'd1
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         Run,
  input  logic         Erase,
  input  logic [9:0]   X_Pos,
  input  logic [9:0]   Y_Pos,
  input  logic         Clear,
  input  logic         Read_Start,
  output logic [W-1:0] Pix_Data,
  output logic         Pix_Valid,
  input  logic         Pix_Ready,
  output logic         Pix_Last,
  output logic         Busy
);

  localparam int unsigned NCELLS = num_cells(GRID);
  localparam int unsigned AW     = $clog2(NCELLS);
  localparam int unsigned CW     = $clog2(GRID + 32'd1);
  localparam logic [3:0] OFF_FIRST  = (BRUSH != 32'd0) ? 4'd0 : 4'd4;
  localparam logic [3:0] OFF_LAST   = (BRUSH != 32'd0) ? 4'd8 : 4'd4;
  localparam logic [3:0] OFF_CENTRE = 4'd4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NCELLS - 32'd1);

  canvas_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic          on_q, on_d, erase_q, erase_d;
  logic [3:0]    off_q, off_d;

  logic [31:0]   x_s, y_s, xcol_s, yrow_s;
  logic          hit_s;
  logic [1:0]    oy_s, ox_s;
  logic [31:0]   rr_s, cc_s;
  logic          tgt_in_s;
  logic [AW-1:0] tgt_addr_s;
  logic [31:0]   inc_s, old_s, res_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_addr_s;
  logic [W-1:0]  ram_wdata_s, ram_rdata_s;

  // Screen coordinates to cell indices; hit_s flags an on-canvas point.
  always_comb begin
    x_s    = {22'd0, X_Pos};
    y_s    = {22'd0, Y_Pos};
    xcol_s = (x_s - X0) / CELL;
    yrow_s = (y_s - Y0) / CELL;
    hit_s  = (x_s >= X0) && (y_s >= Y0) && (xcol_s < GRID) && (yrow_s < GRID);
  end

  // Brush offsets are kept +1 biased so the in-grid test stays unsigned.
  always_comb begin
    oy_s       = 2'(off_q / 4'd3);
    ox_s       = 2'(off_q % 4'd3);
    rr_s       = 32'(row_q) + 32'(oy_s);
    cc_s       = 32'(col_q) + 32'(ox_s);
    tgt_in_s   = (rr_s >= 32'd1) && (rr_s <= GRID) && (cc_s >= 32'd1) && (cc_s <= GRID);
    tgt_addr_s = AW'((rr_s - 32'd1) * GRID + (cc_s - 32'd1));
  end

  // RAM port steering and saturating read-modify-write value.
  always_comb begin
    inc_s = (off_q == OFF_CENTRE) ? INC : (INC >> 2);
    old_s = 32'(ram_rdata_s);
    if (erase_q) begin
      res_s = cell_sat_sub(old_s, inc_s);
    end else begin
      res_s = cell_sat_add(old_s, inc_s, MAX);
    end
    ram_we_s    = 1'b0;
    ram_addr_s  = addr_q;
    ram_wdata_s = {W{1'b0}};
    case (state_q)
      ST_CLEAR:    ram_we_s = 1'b1;
      ST_PAINT_RD: ram_addr_s = tgt_addr_s;
      ST_PAINT_WR: begin
        ram_addr_s  = tgt_addr_s;
        ram_we_s    = 1'b1;
        ram_wdata_s = W'(res_s);
      end
      default:     ram_addr_s = addr_q;
    endcase
  end

  // Next-state logic; Clear overrides everything and restarts the sweep.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    col_d   = col_q;
    on_d    = on_q;
    erase_d = erase_q;
    off_d   = off_q;
    if (Clear) begin
      state_d = ST_CLEAR;
      addr_d  = {AW{1'b0}};
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            addr_d  = {AW{1'b0}};
          end else begin
            addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE: begin
          if (Read_Start) begin
            state_d = ST_READ_ADDR;
            addr_d  = {AW{1'b0}};
          end else if (Run) begin
            state_d = ST_PAINT_RD;
            row_d   = CW'(yrow_s);
            col_d   = CW'(xcol_s);
            on_d    = hit_s;
            erase_d = Erase;
            off_d   = OFF_FIRST;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PAINT_RD: begin
          if (!on_q) begin
            state_d = ST_IDLE;
          end else if (tgt_in_s) begin
            state_d = ST_PAINT_WR;
          end else if (off_q == OFF_LAST) begin
            state_d = ST_IDLE;
          end else begin
            off_d = off_q + 4'd1;
          end
        end
        ST_PAINT_WR: begin
          if (off_q == OFF_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAINT_RD;
            off_d   = off_q + 4'd1;
          end
        end
        ST_READ_ADDR: state_d = ST_READ_HOLD;
        ST_READ_HOLD: begin
          if (!Pix_Ready) begin
            state_d = ST_READ_HOLD;
          end else if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ_ADDR;
            addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = ST_CLEAR;
          addr_d  = {AW{1'b0}};
        end
      endcase
    end
  end

  // State and sequencer registers.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ST_CLEAR;
      addr_q  <= {AW{1'b0}};
      row_q   <= {CW{1'b0}};
      col_q   <= {CW{1'b0}};
      on_q    <= 1'b0;
      erase_q <= 1'b0;
      off_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      on_q    <= on_d;
      erase_q <= erase_d;
      off_q   <= off_d;
    end
  end

  canvas_ram #(.DEPTH(NCELLS), .AW(AW), .W(W)) u_ram (
    .clk_i   (frame_clk),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  assign Pix_Valid = (state_q == ST_READ_HOLD);
  assign Pix_Data  = Pix_Valid ? ram_rdata_s : {W{1'b0}};
  assign Pix_Last  = Pix_Valid && (addr_q == LAST_ADDR);
  assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_canvas_painter.sv
// Self-checking bench for canvas_painter: a cell-array model of the canvas
// predicts paint latency and every streamed word.
module tb_canvas_painter;

  logic        frame_clk = 1'b0;
  logic        Reset, Run, Erase, Clear, Read_Start, Pix_Ready;
  logic [9:0]  X_Pos, Y_Pos;
  logic [15:0] Pix_Data;
  logic        Pix_Valid, Pix_Last, Busy;

  int n_vec = 0;
  int n_err = 0;
  int cells [784];
  int exp_idx = 0;
  bit stream_on = 1'b0;
  bit mon_en = 1'b0;

  canvas_painter dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .Run        (Run),
    .Erase      (Erase),
    .X_Pos      (X_Pos),
    .Y_Pos      (Y_Pos),
    .Clear      (Clear),
    .Read_Start (Read_Start),
    .Pix_Data   (Pix_Data),
    .Pix_Valid  (Pix_Valid),
    .Pix_Ready  (Pix_Ready),
    .Pix_Last   (Pix_Last),
    .Busy       (Busy)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Canvas model: 3x3 brush, centre +-500, neighbours +-125, clamp to [0,2048].
  function automatic void model_paint(input int x, input int y, input bit er, output int lat);
    int c, r, rr, cc, inc, v;
    lat = 0;
    if (x < 200 || y < 44 || (x - 200) / 14 >= 28 || (y - 44) / 14 >= 28) begin
      lat = 1;
      return;
    end
    c = (x - 200) / 14;
    r = (y - 44) / 14;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        rr = r + dy;
        cc = c + dx;
        if (rr < 0 || rr >= 28 || cc < 0 || cc >= 28) begin
          lat += 1;
        end else begin
          inc = (dy == 0 && dx == 0) ? 500 : 125;
          v = cells[rr * 28 + cc];
          if (er) v = (v - inc < 0) ? 0 : v - inc;
          else    v = (v + inc > 2048) ? 2048 : v + inc;
          cells[rr * 28 + cc] = v;
          lat += 2;
        end
      end
    end
  endfunction

  // Stream checker: every valid word must equal the model cell at the next index.
  always @(negedge frame_clk) begin
    if (mon_en) begin
      if (stream_on && Pix_Valid === 1'b1) begin
        if (exp_idx < 784) begin
          chk("pix_data", 32'(Pix_Data), 32'(cells[exp_idx]));
          chk("pix_last", 32'(Pix_Last), 32'(exp_idx == 783));
          if (Pix_Ready === 1'b1) exp_idx++;
        end else begin
          chk("stream_overrun", 32'(exp_idx), 32'd783);
        end
      end else if (stream_on) begin
        chk("last_without_valid", 32'(Pix_Last), 32'd0);
      end else begin
        chk("idle_no_stream", 32'({Pix_Last, Pix_Valid}), 32'd0);
      end
    end
  end

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge frame_clk);
      if (Busy !== 1'b1) return;
      n++;
    end
    chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic paint(input int x, input int y, input bit er, input int pin_lat);
    int lat_m, n;
    model_paint(x, y, er, lat_m);
    @(posedge frame_clk); #2;
    X_Pos = 10'(x);
    Y_Pos = 10'(y);
    Erase = er;
    Run   = 1'b1;
    @(posedge frame_clk); #2;
    Run = 1'b0;
    count_busy(n);
    chk("paint_busy", 32'(n), 32'(lat_m));
    if (pin_lat >= 0) chk("model_latency", 32'(lat_m), 32'(pin_lat));
  endtask

  // mode 0: ready high; 1: random ready; 2: 5-cycle stall on word 3.
  task automatic read_frame(input int mode, input int clear_word);
    int busy_n, first_v, stall;
    bit done;
    busy_n = 0; first_v = -1; stall = 0; done = 1'b0;
    exp_idx = 0;
    stream_on = 1'b1;
    @(posedge frame_clk); #2;
    Read_Start = 1'b1;
    Pix_Ready  = 1'b1;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge frame_clk); #2;
      Read_Start = 1'b0;
      if (mode == 0) begin
        Pix_Ready = 1'b1;
      end else if (mode == 1) begin
        Pix_Ready = 1'($urandom_range(0, 1));
      end else if (exp_idx == 3 && stall < 5) begin
        Pix_Ready = 1'b0;
        stall++;
      end else begin
        Pix_Ready = 1'b1;
      end
      if (clear_word >= 0 && exp_idx == clear_word) begin
        Pix_Ready = 1'b0;
        Clear = 1'b1;
        @(posedge frame_clk); #2;
        Clear = 1'b0;
        stream_on = 1'b0;
        foreach (cells[i]) cells[i] = 0;
        count_busy(busy_n);
        chk("clear_sweep", 32'(busy_n), 32'd784);
        return;
      end
      @(negedge frame_clk);
      if (first_v < 0 && Pix_Valid === 1'b1) first_v = cyc + 1;
      if (Busy === 1'b1) busy_n++;
      else done = 1'b1;
    end
    stream_on = 1'b0;
    chk("read_done", 32'(done), 32'd1);
    chk("xfer_count", 32'(exp_idx), 32'd784);
    chk("first_valid", 32'(first_v), 32'd2);
    if (mode == 0) chk("frame_cycles", 32'(busy_n), 32'd1568);
  endtask

  initial begin
    int n, lat, x, y;
    bit er;
    Reset = 1'b1; Run = 1'b0; Erase = 1'b0; Clear = 1'b0;
    Read_Start = 1'b0; Pix_Ready = 1'b0; X_Pos = 10'd0; Y_Pos = 10'd0;
    foreach (cells[i]) cells[i] = 0;

    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    chk("reset_busy", 32'(Busy), 32'd1);
    chk("reset_valid", 32'(Pix_Valid), 32'd0);
    chk("reset_last", 32'(Pix_Last), 32'd0);
    chk("reset_data", 32'(Pix_Data), 32'd0);
    @(posedge frame_clk); #2;
    Reset = 1'b0;
    mon_en = 1'b1;
    count_busy(n);
    chk("reset_sweep", 32'(n), 32'd784);
    read_frame(0, -1);

    paint(207, 51, 1'b0, 13);
    chk("model_c0_0", 32'(cells[0]), 32'd500);
    chk("model_c0_1", 32'(cells[1]), 32'd125);
    chk("model_c1_0", 32'(cells[28]), 32'd125);
    chk("model_c1_1", 32'(cells[29]), 32'd125);
    chk("model_c0_2", 32'(cells[2]), 32'd0);
    read_frame(1, -1);

    repeat (5) paint(345, 189, 1'b0, 18);
    chk("model_sat_centre", 32'(cells[10 * 28 + 10]), 32'd2048);
    chk("model_sat_nb", 32'(cells[9 * 28 + 9]), 32'd625);
    paint(345, 189, 1'b1, 18);
    chk("model_erase_centre", 32'(cells[10 * 28 + 10]), 32'd1548);
    chk("model_erase_nb", 32'(cells[11 * 28 + 11]), 32'd500);
    paint(199, 100, 1'b0, 1);
    paint(300, 436, 1'b0, 1);
    paint(207, 100, 1'b0, 15);
    read_frame(2, -1);

    for (int i = 0; i < 40; i++) begin
      x  = int'($urandom_range(180, 620));
      y  = int'($urandom_range(30, 460));
      er = ($urandom_range(0, 3) == 0);
      paint(x, y, er, -1);
    end
    read_frame(1, -1);

    read_frame(1, 100);

    model_paint(345, 189, 1'b0, lat);
    @(posedge frame_clk); #2;
    X_Pos = 10'd345; Y_Pos = 10'd189; Erase = 1'b0; Run = 1'b1;
    @(posedge frame_clk); #2;
    Run = 1'b0;
    repeat (3) @(posedge frame_clk);
    #2 Reset = 1'b1;
    @(posedge frame_clk); #2;
    Reset = 1'b0;
    foreach (cells[i]) cells[i] = 0;
    count_busy(n);
    chk("reset_mid_paint_sweep", 32'(n), 32'd784);
    read_frame(0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
